// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the shared execute-stage ALU
// to produce the low WIDTH bits of op_a*op_b, stalling the pipeline while busy.
module alu_mul_seq #(
  parameter int         WIDTH        = 32,
  parameter logic [3:0] FOP_ADD_CODE = 4'd0
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_rda,
  output logic [WIDTH-1:0] alu_rdb,
  output logic [3:0]       alu_fop,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] product_q;
  logic [WIDTH-1:0] acc_step;
  logic             last_step;
  logic             zero_operand;

  // The ALU adds acc+mcand; the sum is only kept when the current multiplier bit is set.
  assign acc_step     = mplier[0] ? alu_result : acc;
  assign last_step    = ((mplier >> 1) == '0) || (count == CW'(WIDTH - 1));
  assign zero_operand = (op_a == '0) || (op_b == '0);

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = zero_operand ? DONE : RUN;
        RUN:  if (last_step) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    alu_own = (state == RUN);
    alu_rda = '0;
    alu_rdb = '0;
    alu_fop = '0;
    if (alu_own) begin
      alu_rda = acc;
      alu_rdb = mcand;
      alu_fop = FOP_ADD_CODE;
    end
  end

  assign product = product_q;

  // A flush only redirects the FSM; datapath registers are left as they are.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      state <= state_next;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (start) begin
              acc    <= '0;
              mcand  <= op_a;
              mplier <= op_b;
              count  <= '0;
              if (zero_operand) product_q <= '0;
            end
          end
          RUN: begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_step) product_q <= acc_step;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: expected products and done cycles are queued
// at start and compared when done pulses; a simple adder stands in for the ALU.
module tb_alu_mul_seq;

  typedef struct {
    logic [31:0] prod;
    int          done_cyc;
  } exp_t;

  logic        clk;
  logic        nRst;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        alu_own;
  logic [31:0] alu_rda;
  logic [31:0] alu_rdb;
  logic [3:0]  alu_fop;
  logic [31:0] alu_result;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   pushed = 0;
  exp_t sb[$];

  alu_mul_seq #(.WIDTH(32), .FOP_ADD_CODE(4'd0)) dut (
    .clk(clk), .nRst(nRst), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .product(product),
    .alu_own(alu_own), .alu_rda(alu_rda), .alu_rdb(alu_rdb), .alu_fop(alu_fop),
    .alu_result(alu_result)
  );

  // Shared ALU in add mode.
  assign alu_result = alu_rda + alu_rdb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int runLen(input logic [31:0] a, input logic [31:0] b);
    if (a == 0 || b == 0) return 0;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  // Called just after a negedge with busy low; returns just after the next negedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      e.prod     = a * b;
      e.done_cyc = cyc + runLen(a, b);
      sb.push_back(e);
      pushed++;
    end
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    checkOutput("wait_done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_alu_own"}, 32'(alu_own), 32'd0);
    checkOutput({tag, "_alu_rda"}, alu_rda, 32'd0);
    checkOutput({tag, "_alu_rdb"}, alu_rdb, 32'd0);
    checkOutput({tag, "_alu_fop"}, 32'(alu_fop), 32'd0);
    checkOutput({tag, "_product"}, product, 32'd0);
  endtask

  // Continuous monitor: ALU drive rules, RUN ownership and scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (nRst) begin
      if (!alu_own) begin
        checkOutput("alu_rda_released", alu_rda, 32'd0);
        checkOutput("alu_rdb_released", alu_rdb, 32'd0);
        checkOutput("alu_fop_released", 32'(alu_fop), 32'd0);
      end
      if (busy && !done) begin
        checkOutput("alu_own_run", 32'(alu_own), 32'd1);
        checkOutput("alu_fop_run", 32'(alu_fop), 32'd0);
      end
      if (done) begin
        done_seen++;
        checkOutput("alu_own_done", 32'(alu_own), 32'd0);
        checkOutput("busy_done", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("product", product, e.prod);
          checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRst  = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1 nRst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] reset values");
    checkResetOutputs("reset");
    nRst = 1'b1;
    @(negedge clk);
    #1;

    $display("[TB] reset during RUN");
    applyStimulus(32'd3, 32'hFF, 0);
    repeat (2) @(negedge clk);
    #1;
    nRst = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    @(negedge clk);
    #1;
    nRst = 1'b1;
    @(negedge clk);
    #1;
    applyStimulus(32'd2, 32'd2, 1);
    waitDone();

    $display("[TB] zero operand shortcut");
    applyStimulus(32'h12345678, 32'd0, 1);
    waitDone();

    $display("[TB] all ones");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    waitDone();

    $display("[TB] 6 x 7");
    applyStimulus(32'd6, 32'd7, 1);
    waitDone();

    $display("[TB] flush during RUN");
    applyStimulus(32'd5, 32'h80000000, 0);
    repeat (9) @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    checkOutput("flush_product", product, 32'd42);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("flush_product_held", product, 32'd42);
    checkOutput("flush_busy_held", 32'(busy), 32'd0);

    $display("[TB] start while busy");
    applyStimulus(32'd9, 32'd3, 1);
    op_a  = 32'd1;
    op_b  = 32'd1;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    waitDone();
    repeat (5) @(negedge clk);
    #1;
    checkOutput("product_after_ignored_start", product, 32'd27);
    checkOutput("done_count", 32'(done_seen), 32'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
